// File: rtl/memcore_uram_arbiter.sv
// Round-robin arbiter that time-shares one simple-dual-port URAM between NUM_PORTS requesters.
// Writes go to memory port 0 and reads to port 1. Read responses are steered back by a tag pipeline.
module memcore_uram_arbiter #(
    parameter int NUM_PORTS     = 2,
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 6,
    parameter int READ_LATENCY  = 1
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [NUM_PORTS-1:0]               wr_valid,
    output logic [NUM_PORTS-1:0]               wr_ready,
    input  logic [NUM_PORTS*ADDRESS_WIDTH-1:0] wr_addr,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]    wr_data,
    input  logic [NUM_PORTS-1:0]               rd_valid,
    output logic [NUM_PORTS-1:0]               rd_ready,
    input  logic [NUM_PORTS*ADDRESS_WIDTH-1:0] rd_addr,
    output logic [NUM_PORTS-1:0]               rd_resp_valid,
    output logic [DATA_WIDTH-1:0]              rd_resp_data,
    output logic [ADDRESS_WIDTH-1:0]           mem_address0,
    output logic                               mem_ce0,
    output logic                               mem_we0,
    output logic [DATA_WIDTH-1:0]              mem_d0,
    output logic [ADDRESS_WIDTH-1:0]           mem_address1,
    output logic                               mem_ce1,
    input  logic [DATA_WIDTH-1:0]              mem_q1
);

    localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    // Returns {found, index} of the first set request after ptr, wrapping around.
    function automatic logic [IDX_W:0] rr_pick(input logic [NUM_PORTS-1:0] req,
                                               input logic [IDX_W-1:0] ptr);
        logic             found;
        logic [IDX_W-1:0] win;
        logic [IDX_W-1:0] cand;
        found = 1'b0;
        win   = '0;
        for (int j = 1; j <= NUM_PORTS; j++) begin
            cand = IDX_W'((int'(ptr) + j) % NUM_PORTS);
            if (!found && req[cand]) begin
                found = 1'b1;
                win   = cand;
            end else begin
                found = found;
            end
        end
        return {found, win};
    endfunction

    function automatic logic [NUM_PORTS-1:0] to_onehot(input logic [IDX_W-1:0] idx);
        logic [NUM_PORTS-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

    logic [IDX_W-1:0]         wr_ptr_r;
    logic [IDX_W-1:0]         rd_ptr_r;
    logic [IDX_W:0]           wr_pick_s;
    logic [IDX_W:0]           rd_pick_s;
    logic                     wr_found_s;
    logic                     rd_found_s;
    logic [IDX_W-1:0]         wr_win_s;
    logic [IDX_W-1:0]         rd_win_s;
    logic [ADDRESS_WIDTH-1:0] wr_win_addr_s;
    logic [ADDRESS_WIDTH-1:0] rd_win_addr_s;
    logic [DATA_WIDTH-1:0]    wr_win_data_s;
    logic                     hazard_s;
    logic                     rd_grant_s;

    logic [READ_LATENCY:0]    tag_v_r;
    logic [NUM_PORTS-1:0]     tag_id_r [READ_LATENCY+1];

    assign wr_pick_s     = rr_pick(wr_valid, wr_ptr_r);
    assign rd_pick_s     = rr_pick(rd_valid, rd_ptr_r);
    assign wr_found_s    = wr_pick_s[IDX_W];
    assign rd_found_s    = rd_pick_s[IDX_W];
    assign wr_win_s      = wr_pick_s[IDX_W-1:0];
    assign rd_win_s      = rd_pick_s[IDX_W-1:0];
    assign wr_win_addr_s = wr_addr[wr_win_s*ADDRESS_WIDTH +: ADDRESS_WIDTH];
    assign rd_win_addr_s = rd_addr[rd_win_s*ADDRESS_WIDTH +: ADDRESS_WIDTH];
    assign wr_win_data_s = wr_data[wr_win_s*DATA_WIDTH +: DATA_WIDTH];

    // A read that targets the address being written this cycle waits one cycle so it sees the new data.
    assign hazard_s   = wr_found_s && rd_found_s && (rd_win_addr_s == wr_win_addr_s);
    assign rd_grant_s = rd_found_s && !hazard_s;

    // Combinational grants, forced low while reset is asserted.
    always_comb begin
        wr_ready = '0;
        rd_ready = '0;
        if (reset) begin
            wr_ready = '0;
            rd_ready = '0;
        end else begin
            if (wr_found_s) begin
                wr_ready = to_onehot(wr_win_s);
            end else begin
                wr_ready = '0;
            end
            if (rd_grant_s) begin
                rd_ready = to_onehot(rd_win_s);
            end else begin
                rd_ready = '0;
            end
        end
    end

    // Round-robin pointers remember the last winner of each channel.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_r <= IDX_W'(NUM_PORTS - 1);
            rd_ptr_r <= IDX_W'(NUM_PORTS - 1);
        end else begin
            if (wr_found_s) wr_ptr_r <= wr_win_s;
            if (rd_grant_s) rd_ptr_r <= rd_win_s;
        end
    end

    // Registered memory commands; address and data hold when idle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_ce0      <= 1'b0;
            mem_we0      <= 1'b0;
            mem_address0 <= '0;
            mem_d0       <= '0;
            mem_ce1      <= 1'b0;
            mem_address1 <= '0;
        end else begin
            mem_ce0 <= wr_found_s;
            mem_we0 <= wr_found_s;
            mem_ce1 <= rd_grant_s;
            if (wr_found_s) begin
                mem_address0 <= wr_win_addr_s;
                mem_d0       <= wr_win_data_s;
            end
            if (rd_grant_s) mem_address1 <= rd_win_addr_s;
        end
    end

    // Tag pipeline tracking which requester owns each read in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tag_v_r <= '0;
            for (int i = 0; i <= READ_LATENCY; i++) tag_id_r[i] <= '0;
        end else begin
            tag_v_r     <= {tag_v_r[READ_LATENCY-1:0], rd_grant_s};
            tag_id_r[0] <= rd_grant_s ? to_onehot(rd_win_s) : '0;
            for (int i = 1; i <= READ_LATENCY; i++) tag_id_r[i] <= tag_id_r[i-1];
        end
    end

    // Response strobe and data, captured when the oldest tag matures.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_resp_valid <= '0;
            rd_resp_data  <= '0;
        end else if (tag_v_r[READ_LATENCY]) begin
            rd_resp_valid <= tag_id_r[READ_LATENCY];
            rd_resp_data  <= mem_q1;
        end else begin
            rd_resp_valid <= '0;
        end
    end

endmodule

// File: tb/tb_memcore_uram_arbiter.sv
// Bench for memcore_uram_arbiter: two instances (read latency 1 and 3) on shared stimulus,
// each with a memory model and a cycle-level behavioural reference.
module tb_memcore_uram_arbiter;

    logic        clk;
    logic        reset;
    logic [1:0]  wr_valid, rd_valid;
    logic [11:0] wr_addr, rd_addr;
    logic [63:0] wr_data;

    logic [1:0]  wr_ready_a, rd_ready_a, rv_a, wr_ready_b, rd_ready_b, rv_b;
    logic [31:0] rd_a, rd_b, d0_a, d0_b, q1_a, q1_b;
    logic [5:0]  a0_a, a1_a, a0_b, a1_b;
    logic        ce0_a, we0_a, ce1_a, ce0_b, we0_b, ce1_b;

    int checks   = 0;
    int failures = 0;

    memcore_uram_arbiter #(.NUM_PORTS(2), .DATA_WIDTH(32), .ADDRESS_WIDTH(6), .READ_LATENCY(1)) dut_a (
        .clk(clk), .reset(reset), .wr_valid(wr_valid), .wr_ready(wr_ready_a), .wr_addr(wr_addr),
        .wr_data(wr_data), .rd_valid(rd_valid), .rd_ready(rd_ready_a), .rd_addr(rd_addr),
        .rd_resp_valid(rv_a), .rd_resp_data(rd_a), .mem_address0(a0_a), .mem_ce0(ce0_a),
        .mem_we0(we0_a), .mem_d0(d0_a), .mem_address1(a1_a), .mem_ce1(ce1_a), .mem_q1(q1_a));

    memcore_uram_arbiter #(.NUM_PORTS(2), .DATA_WIDTH(32), .ADDRESS_WIDTH(6), .READ_LATENCY(3)) dut_b (
        .clk(clk), .reset(reset), .wr_valid(wr_valid), .wr_ready(wr_ready_b), .wr_addr(wr_addr),
        .wr_data(wr_data), .rd_valid(rd_valid), .rd_ready(rd_ready_b), .rd_addr(rd_addr),
        .rd_resp_valid(rv_b), .rd_resp_data(rd_b), .mem_address0(a0_b), .mem_ce0(ce0_b),
        .mem_we0(we0_b), .mem_d0(d0_b), .mem_address1(a1_b), .mem_ce1(ce1_b), .mem_q1(q1_b));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Simple-dual-port memories with 1- and 3-cycle read latency.
    logic [31:0] mem_a [64];
    logic [31:0] mem_b [64];
    logic [31:0] pipe_a;
    logic [31:0] pipe_b [3];
    initial begin
        for (int i = 0; i < 64; i++) begin
            mem_a[i] = 32'h0;
            mem_b[i] = 32'h0;
        end
        pipe_a = 32'h0;
        for (int i = 0; i < 3; i++) pipe_b[i] = 32'h0;
    end
    always @(posedge clk) begin
        if (ce0_a && we0_a) mem_a[a0_a] <= d0_a;
        if (ce1_a) pipe_a <= mem_a[a1_a];
        if (ce0_b && we0_b) mem_b[a0_b] <= d0_b;
        if (ce1_b) pipe_b[0] <= mem_b[a1_b];
        pipe_b[1] <= pipe_b[0];
        pipe_b[2] <= pipe_b[1];
    end
    assign q1_a = pipe_a;
    assign q1_b = pipe_b[2];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // Reference state: pointers, memory image, response schedule keyed by due cycle, expected registers.
    int          m_wptr [2];
    int          m_rptr [2];
    int          m_cyc  [2];
    logic [31:0] m_mem  [2][64];
    logic [1:0]  s_id   [2][16];
    logic [31:0] s_data [2][16];
    logic        e_ce0 [2], e_ce1 [2];
    logic [5:0]  e_a0 [2], e_a1 [2];
    logic [31:0] e_d0 [2], e_rd [2];

    initial begin
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 64; i++) m_mem[k][i] = 32'h0;
            for (int i = 0; i < 16; i++) begin
                s_id[k][i]   = 2'b00;
                s_data[k][i] = 32'h0;
            end
            m_cyc[k] = 0;
        end
    end

    task automatic model_step(input int k, input int lat, input logic [1:0] wrdy, input logic [1:0] rrdy,
                              input logic [1:0] rv, input logic [31:0] rd, input logic ce0,
                              input logic we0, input logic ce1, input logic [5:0] a0,
                              input logic [5:0] a1, input logic [31:0] d0);
        int         wwin, rwin, idx, slot;
        logic [1:0] exp_rv;
        if (reset) begin
            chk($sformatf("k%0d_rst_wr_ready", k), wrdy, 2'b00);
            chk($sformatf("k%0d_rst_rd_ready", k), rrdy, 2'b00);
            chk($sformatf("k%0d_rst_resp", k), {rv, rd}, 34'h0);
            chk($sformatf("k%0d_rst_mem", k), {ce0, we0, ce1, a0, a1, d0}, 47'h0);
            m_wptr[k] = 1;
            m_rptr[k] = 1;
            e_ce0[k] = 1'b0; e_ce1[k] = 1'b0; e_a0[k] = 6'h0; e_a1[k] = 6'h0;
            e_d0[k] = 32'h0; e_rd[k] = 32'h0;
            for (int i = 0; i < 16; i++) s_id[k][i] = 2'b00;
        end else begin
            slot   = m_cyc[k] % 16;
            exp_rv = s_id[k][slot];
            if (exp_rv != 2'b00) e_rd[k] = s_data[k][slot];
            s_id[k][slot] = 2'b00;
            chk($sformatf("k%0d_resp_valid c%0d", k, m_cyc[k]), rv, exp_rv);
            chk($sformatf("k%0d_resp_data c%0d", k, m_cyc[k]), rd, e_rd[k]);
            chk($sformatf("k%0d_port0 c%0d", k, m_cyc[k]), {ce0, we0, a0, d0}, {e_ce0[k], e_ce0[k], e_a0[k], e_d0[k]});
            chk($sformatf("k%0d_port1 c%0d", k, m_cyc[k]), {ce1, a1}, {e_ce1[k], e_a1[k]});
            wwin = -1;
            rwin = -1;
            for (int j = 1; j <= 2; j++) begin
                idx = (m_wptr[k] + j) % 2;
                if (wwin < 0 && wr_valid[idx]) wwin = idx;
                idx = (m_rptr[k] + j) % 2;
                if (rwin < 0 && rd_valid[idx]) rwin = idx;
            end
            if (wwin >= 0 && rwin >= 0 && rd_addr[rwin*6 +: 6] == wr_addr[wwin*6 +: 6]) rwin = -1;
            chk($sformatf("k%0d_wr_ready c%0d", k, m_cyc[k]), wrdy, (wwin >= 0) ? 2'(1 << wwin) : 2'b00);
            chk($sformatf("k%0d_rd_ready c%0d", k, m_cyc[k]), rrdy, (rwin >= 0) ? 2'(1 << rwin) : 2'b00);
            e_ce1[k] = (rwin >= 0);
            if (rwin >= 0) begin
                m_rptr[k] = rwin;
                e_a1[k]   = rd_addr[rwin*6 +: 6];
                slot      = (m_cyc[k] + 2 + lat) % 16;
                s_id[k][slot]   = 2'(1 << rwin);
                s_data[k][slot] = m_mem[k][e_a1[k]];
            end
            e_ce0[k] = (wwin >= 0);
            if (wwin >= 0) begin
                m_wptr[k] = wwin;
                e_a0[k]   = wr_addr[wwin*6 +: 6];
                e_d0[k]   = wr_data[wwin*32 +: 32];
                m_mem[k][e_a0[k]] = e_d0[k];
            end
        end
        m_cyc[k]++;
    endtask

    // Every cycle both instances are compared against the reference.
    always @(negedge clk) begin
        model_step(0, 1, wr_ready_a, rd_ready_a, rv_a, rd_a, ce0_a, we0_a, ce1_a, a0_a, a1_a, d0_a);
        model_step(1, 3, wr_ready_b, rd_ready_b, rv_b, rd_b, ce0_b, we0_b, ce1_b, a0_b, a1_b, d0_b);
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    logic [1:0]  ord_id   [4];
    logic [31:0] ord_data [4];

    initial begin
        reset = 1'b1;
        wr_valid = 2'b00; rd_valid = 2'b00;
        wr_addr = 12'h0; rd_addr = 12'h0; wr_data = 64'h0;
        ord_id[0] = 2'b01; ord_id[1] = 2'b10; ord_id[2] = 2'b01; ord_id[3] = 2'b10;
        ord_data[0] = 32'hA1; ord_data[1] = 32'hB2; ord_data[2] = 32'hA1; ord_data[3] = 32'hB2;
        @(negedge clk);
        chk("reset_outputs", {wr_ready_a, rd_ready_a, rv_a, rd_a, ce0_a, ce1_a}, 40'h0);
        repeat (2) next_cycle();

        // Contention: both requesters write continuously.
        reset    = 1'b0;
        wr_valid = 2'b11;
        wr_addr  = {6'd2, 6'd1};
        wr_data  = {32'hB2, 32'hA1};
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i < 4) chk($sformatf("contention_grant%0d", i), wr_ready_a, (i % 2 == 0) ? 2'b01 : 2'b10);
            if (i > 0) chk($sformatf("contention_write%0d", i), ce0_a, 1'b1);
            next_cycle();
            if (i == 3) wr_valid = 2'b00;
        end

        // Single write then read.
        wr_valid = 2'b01; wr_addr = {6'd0, 6'd5}; wr_data = {32'h0, 32'hDEADBEEF};
        @(negedge clk);
        chk("single_wr_grant", wr_ready_a, 2'b01);
        next_cycle();
        wr_valid = 2'b00;
        @(negedge clk);
        chk("single_mem_write", {ce0_a, we0_a, a0_a, d0_a}, {1'b1, 1'b1, 6'd5, 32'hDEADBEEF});
        next_cycle();
        rd_valid = 2'b10; rd_addr = {6'd5, 6'd0};
        @(negedge clk);
        chk("single_rd_grant", rd_ready_a, 2'b10);
        next_cycle();
        rd_valid = 2'b00;
        next_cycle();
        next_cycle();
        @(negedge clk);
        chk("single_resp_lat1", {rv_a, rd_a}, {2'b10, 32'hDEADBEEF});
        next_cycle();
        next_cycle();
        @(negedge clk);
        chk("single_resp_lat3", {rv_b, rd_b}, {2'b10, 32'hDEADBEEF});
        next_cycle();

        // Same-address hazard, then different addresses in the same cycle.
        wr_valid = 2'b01; wr_addr = {6'd0, 6'd3}; wr_data = {32'h0, 32'h11};
        rd_valid = 2'b10; rd_addr = {6'd3, 6'd0};
        @(negedge clk);
        chk("hazard_stall", {wr_ready_a, rd_ready_a}, {2'b01, 2'b00});
        next_cycle();
        wr_valid = 2'b00;
        @(negedge clk);
        chk("hazard_release", rd_ready_a, 2'b10);
        next_cycle();
        rd_valid = 2'b00;
        next_cycle();
        next_cycle();
        @(negedge clk);
        chk("hazard_resp", {rv_a, rd_a}, {2'b10, 32'h11});
        next_cycle();
        wr_valid = 2'b01; wr_addr = {6'd0, 6'd7}; wr_data = {32'h0, 32'h77};
        rd_valid = 2'b10; rd_addr = {6'd3, 6'd0};
        @(negedge clk);
        chk("no_hazard_diff_addr", {wr_ready_a, rd_ready_a}, {2'b01, 2'b10});
        next_cycle();
        wr_valid = 2'b00; rd_valid = 2'b00;
        repeat (6) next_cycle();

        // Ordering with read latency 3: four back-to-back alternating reads.
        rd_valid = 2'b11; rd_addr = {6'd2, 6'd1};
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            if (i < 4) chk($sformatf("order_grant%0d", i), rd_ready_b, ord_id[i]);
            if (i == 4) chk("order_not_early", rv_b, 2'b00);
            if (i >= 5) chk($sformatf("order_resp%0d", i - 5), {rv_b, rd_b}, {ord_id[i-5], ord_data[i-5]});
            next_cycle();
            if (i == 3) rd_valid = 2'b00;
        end
        repeat (4) next_cycle();

        // Reset with two reads in flight; last pre-reset winner is requester 0.
        rd_valid = 2'b10;
        next_cycle();
        rd_valid = 2'b01;
        next_cycle();
        rd_valid = 2'b11;
        reset    = 1'b1;
        #1;
        chk("reset_async_a", {wr_ready_a, rd_ready_a, rv_a, rd_a, ce0_a, ce1_a, a1_a}, 46'h0);
        chk("reset_async_b", {rd_ready_b, rv_b, ce1_b, a1_b}, 11'h0);
        next_cycle();
        next_cycle();
        reset    = 1'b0;
        rd_valid = 2'b00;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk($sformatf("no_resp_after_reset%0d", i), {rv_a, rv_b}, 4'h0);
            next_cycle();
        end
        rd_valid = 2'b11;
        @(negedge clk);
        chk("first_grant_after_reset", {rd_ready_a, rd_ready_b}, {2'b01, 2'b01});
        next_cycle();
        rd_valid = 2'b00;
        repeat (8) next_cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/memcore_uram_arbiter.md
# memcore_uram_arbiter

Round-robin arbiter that shares one simple-dual-port URAM memory core between `NUM_PORTS` requesters. Writes from all requesters are arbitrated onto memory port 0 and reads onto memory port 1, independently. Each read response is routed back to the requester that issued it. The block sits between per-task buffer accessors and a single `memcore_uram_simple` instance, so several producers and consumers can time-share one URAM bank.

## Interface
Parameters:
- `NUM_PORTS`, 2: number of requesters (≥1).
- `DATA_WIDTH`, 32: memory word width.
- `ADDRESS_WIDTH`, 6: memory address width.
- `READ_LATENCY`, 1: cycles from `mem_ce1` high to valid `mem_q1` (≥1).

Ports (request buses are flattened; requester i occupies slice i):
- `clk` in 1: clock; all logic is rising-edge.
- `reset` in 1: asynchronous, active-high reset.
- `wr_valid` in NUM_PORTS: write request per requester.
- `wr_ready` out NUM_PORTS: write grant. The handshake completes when valid && ready.
- `wr_addr` in NUM_PORTS*ADDRESS_WIDTH: write addresses.
- `wr_data` in NUM_PORTS*DATA_WIDTH: write data.
- `rd_valid` in NUM_PORTS: read request.
- `rd_ready` out NUM_PORTS: read grant.
- `rd_addr` in NUM_PORTS*ADDRESS_WIDTH: read addresses.
- `rd_resp_valid` out NUM_PORTS: one-cycle response strobe, one-hot.
- `rd_resp_data` out DATA_WIDTH: response data, shared by all requesters.
- `mem_address0` out ADDRESS_WIDTH, `mem_ce0` out 1, `mem_we0` out 1, `mem_d0` out DATA_WIDTH: memory write port.
- `mem_address1` out ADDRESS_WIDTH, `mem_ce1` out 1: memory read port.
- `mem_q1` in DATA_WIDTH: memory read data.

## Operation
- **Write arbiter.** Round-robin over the `wr_valid` bits. Search starts at `wr_ptr+1` (mod NUM_PORTS). At most one `wr_ready` bit is high, and only for a requester whose valid is high. `wr_ready` is combinational from the valids and the pointer. On a handshake, `wr_ptr` ← the winner index.
- **Read arbiter.** Same scheme with its own pointer, `rd_ptr`.
- **Issue.** A handshake in cycle T registers the command onto the memory port, which is driven during T+1:
  - Write: `mem_ce0=mem_we0=1`, with address and data.
  - Read: `mem_ce1=1` with address.
  - With no handshake, `mem_ce0`, `mem_we0` and `mem_ce1` are 0. Address and data outputs hold their previous values.
- **Write/read address hazard.** If in the same cycle both arbiters have a candidate winner and the read winner's address equals the write winner's address:
  - The read grant is withheld: all `rd_ready`=0 and `rd_ptr` is unchanged.
  - The write proceeds.
  - The read is granted the next cycle, so it returns the newly written data.
  - Different addresses never stall.
- **Response tracking.** Each issued read pushes a tag (valid bit plus one-hot requester id) into a shift pipeline of depth `READ_LATENCY+1`. When the tag reaches the end, `rd_resp_valid[id]` is asserted for one cycle and `rd_resp_data` is registered from `mem_q1`.
  - There is no response backpressure; requesters must accept responses.
  - Responses return in issue order, one per cycle at most.
- **Reset.** On assertion, immediately and asynchronously:
  - All outputs go to 0.
  - `wr_ptr` and `rd_ptr` go to NUM_PORTS-1, so requester 0 has first priority.
  - All in-flight tags are cleared.
  - Reads accepted before reset never produce a response.

## Timing
- Grant is combinational in the request cycle T. The memory command is visible at T+1.
- Read response for a read granted at T: `rd_resp_valid` and `rd_resp_data` are valid at T+2+READ_LATENCY. With READ_LATENCY=1 this is T+3.
- Throughput: one write and one read per cycle across all requesters, except for the hazard stall (one cycle).
- Under continuous contention each requester is granted at least once every NUM_PORTS cycles per channel.
- A requester must hold `valid`, `addr` and `data` stable until it sees `ready`.
- Values after reset: `wr_ready`=0, `rd_ready`=0, `rd_resp_valid`=0, `rd_resp_data`=0, `mem_*`=0.
- First grant is possible in the first cycle after `reset` deasserts.

## Test plan
- **Single write then read.** NUM_PORTS=2, READ_LATENCY=1. Requester 0 writes 0xDEADBEEF to address 5 at T0; requester 1 reads address 5 at T2.
  - Required: `mem_ce0`/`mem_we0`=1 at T1; `rd_resp_valid`=2'b10 with data 0xDEADBEEF at T5.
- **Contention.** Both requesters hold `wr_valid` for 4 cycles after reset.
  - Required: grants 0,1,0,1; `wr_ready` is one-hot each cycle; 4 memory writes on consecutive cycles.
- **Hazard.** In the same cycle, requester 0 writes 0x11 to address 3 and requester 1 reads address 3.
  - Required: `rd_ready`=0 that cycle and 1 the next; response data 0x11.
- **Ordering.** READ_LATENCY=3; 4 back-to-back reads alternating requesters.
  - Required: responses on 4 consecutive cycles starting 5 cycles after the first grant, with ids alternating in the same order as issued.
- **Reset mid-flight.** Issue 2 reads, then assert `reset` one cycle later for 2 cycles.
  - Required: outputs 0 immediately; no `rd_resp_valid` after reset; first grant after release goes to requester 0.
